// File: rtl/prog_run_seq.sv
// prog_run_seq: on-board host that launches the three core programs, reads back and checks their results
module prog_run_seq #(
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] exp1,
  input  logic [7:0]  exp2,
  input  logic [7:0]  exp3,
  input  logic        core_done,
  output logic        core_reset,
  output logic        dm_ren,
  output logic [7:0]  dm_raddr,
  input  logic [7:0]  dm_rdata,
  output logic [1:0]  prog_idx,
  output logic        busy,
  output logic        all_done,
  output logic [2:0]  pass,
  output logic [2:0]  timeout,
  output logic [15:0] result1,
  output logic [7:0]  result2,
  output logic [7:0]  result3,
  output logic [15:0] cyc_ct
);
  typedef enum logic [2:0] {IDLE, RST, RUN, READ, CHECK, NEXT, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] rst_ct_q, rst_ct_d;
  logic [1:0] rd_q, rd_d;
  logic [15:0] exp1_q, exp1_d;
  logic [7:0] exp2_q, exp2_d, exp3_q, exp3_d;
  logic core_reset_q, busy_q, all_done_q, dm_ren_q, dm_ren_d;
  logic [7:0] dm_raddr_q, dm_raddr_d;
  logic [1:0] prog_q, prog_d;
  logic [2:0] pass_q, pass_d, timeout_q, timeout_d;
  logic [15:0] result1_q, result1_d, cyc_q, cyc_d;
  logic [7:0] result2_q, result2_d, result3_q, result3_d;
  assign core_reset = core_reset_q;
  assign dm_ren = dm_ren_q;
  assign dm_raddr = dm_raddr_q;
  assign prog_idx = prog_q;
  assign busy = busy_q;
  assign all_done = all_done_q;
  assign pass = pass_q;
  assign timeout = timeout_q;
  assign result1 = result1_q;
  assign result2 = result2_q;
  assign result3 = result3_q;
  assign cyc_ct = cyc_q;
  // next-state: launch, hold core in reset, run with watchdog, read results, compare, advance
  always_comb begin
    state_d = state_q;
    rst_ct_d = rst_ct_q;
    rd_d = rd_q;
    exp1_d = exp1_q;
    exp2_d = exp2_q;
    exp3_d = exp3_q;
    dm_ren_d = 1'b0;
    dm_raddr_d = dm_raddr_q;
    prog_d = prog_q;
    pass_d = pass_q;
    timeout_d = timeout_q;
    result1_d = result1_q;
    result2_d = result2_q;
    result3_d = result3_q;
    cyc_d = cyc_q;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d = RST;
        rst_ct_d = '0;
        exp1_d = exp1;
        exp2_d = exp2;
        exp3_d = exp3;
        prog_d = '0;
        pass_d = '0;
        timeout_d = '0;
        result1_d = '0;
        result2_d = '0;
        result3_d = '0;
        cyc_d = '0;
      end
      RST: if (rst_ct_q == 4'(RST_CYCLES - 1)) begin
        state_d = RUN;
        cyc_d = 16'd1;
      end else rst_ct_d = rst_ct_q + 4'd1;
      RUN: if (core_done) begin
        state_d = READ;
        rd_d = '0;
        dm_ren_d = 1'b1;
        dm_raddr_d = prog_q == 2'd0 ? 8'd4 : prog_q == 2'd1 ? 8'd7 : 8'd127;
      end else if (cyc_q == 16'(TIMEOUT)) begin
        state_d = NEXT;
        timeout_d[prog_q] = 1'b1;
      end else cyc_d = cyc_q + 16'd1;
      READ: begin
        rd_d = rd_q + 2'd1;
        if (rd_q == 2'd0) begin
          dm_ren_d = prog_q == 2'd0;
          dm_raddr_d = prog_q == 2'd0 ? 8'd5 : dm_raddr_q;
        end else if (rd_q == 2'd1) begin
          result1_d[15:8] = prog_q == 2'd0 ? dm_rdata : result1_q[15:8];
          result2_d = prog_q == 2'd1 ? dm_rdata : result2_q;
          result3_d = prog_q == 2'd2 ? dm_rdata : result3_q;
          state_d = prog_q == 2'd0 ? READ : CHECK;
        end else begin
          result1_d[7:0] = dm_rdata;
          state_d = CHECK;
        end
      end
      CHECK: begin
        pass_d[prog_q] = prog_q == 2'd0 ? result1_q == exp1_q :
                         prog_q == 2'd1 ? result2_q == exp2_q : result3_q == exp3_q;
        state_d = NEXT;
      end
      NEXT: if (prog_q == 2'd2) state_d = DONE;
      else begin
        prog_d = prog_q + 2'd1;
        rst_ct_d = '0;
        state_d = RST;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and registered outputs; status flags follow the state being entered
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rst_ct_q <= '0;
      rd_q <= '0;
      exp1_q <= '0;
      exp2_q <= '0;
      exp3_q <= '0;
      core_reset_q <= 1'b1;
      busy_q <= 1'b0;
      all_done_q <= 1'b0;
      dm_ren_q <= 1'b0;
      dm_raddr_q <= '0;
      prog_q <= '0;
      pass_q <= '0;
      timeout_q <= '0;
      result1_q <= '0;
      result2_q <= '0;
      result3_q <= '0;
      cyc_q <= '0;
    end else begin
      state_q <= state_d;
      rst_ct_q <= rst_ct_d;
      rd_q <= rd_d;
      exp1_q <= exp1_d;
      exp2_q <= exp2_d;
      exp3_q <= exp3_d;
      core_reset_q <= state_d != RUN;
      busy_q <= !(state_d inside {IDLE, DONE});
      all_done_q <= state_d == DONE;
      dm_ren_q <= dm_ren_d;
      dm_raddr_q <= dm_raddr_d;
      prog_q <= prog_d;
      pass_q <= pass_d;
      timeout_q <= timeout_d;
      result1_q <= result1_d;
      result2_q <= result2_d;
      result3_q <= result3_d;
      cyc_q <= cyc_d;
    end
  end
endmodule

// File: doc/prog_run_seq.md
Name: prog_run_seq

Overview:
- Hardware host for the core `top`: the in-silicon counterpart of the simulation bench. Runs the three programs back to back on the board.
- For each program it pulses the core's reset to start it, waits for `done`, then reads the result bytes out of data memory through a read port.
- Compares each result against an expected value latched at `start` and reports per-program pass, timeout and cycle count.
- Sits beside `top` in the FPGA wrapper and owns the core reset and the data-memory read port.

Parameters:
- RST_CYCLES, 2: cycles `core_reset` is held high before each program launch (range 1..15).
- TIMEOUT, 65535: RUN cycle limit before a program is declared hung (16-bit).

Ports:
- clk  in  1  system clock; all logic rising-edge.
- reset  in  1  synchronous, active-high.
- start  in  1  launch request; honoured only in IDLE or DONE.
- exp1  in  16  expected program-1 product.
- exp2  in  8  expected program-2 match count.
- exp3  in  8  expected program-3 minimum distance.
- core_done  in  1  `done` from the core.
- core_reset  out  1  reset into the core.
- dm_ren  out  1  data-memory read enable.
- dm_raddr  out  8  data-memory read address.
- dm_rdata  in  8  read data; valid the cycle after `dm_ren`.
- prog_idx  out  2  current program, 0..2.
- busy  out  1  high in RST/RUN/READ/CHECK/NEXT.
- all_done  out  1  high in DONE.
- pass  out  3  per-program match flag.
- timeout  out  3  per-program hang flag.
- result1  out  16  product read back as {mem[4], mem[5]}.
- result2  out  8  mem[7].
- result3  out  8  mem[127].
- cyc_ct  out  16  RUN cycle count of the most recent program.

Behaviour:
- Reset values: `core_reset`=1, `busy`=0, `all_done`=0, `dm_ren`=0, `dm_raddr`=0, `prog_idx`=0, `pass`=0, `timeout`=0, all results=0, `cyc_ct`=0, state IDLE.
- Reset mid-operation: the reset values apply on the next edge.
- States: IDLE, RST, RUN, READ, CHECK, NEXT, DONE.
- IDLE/DONE:
  - `core_reset`=1.
  - `start` latches exp1..3; clears `pass`, `timeout`, results, `cyc_ct` and `all_done`; sets `prog_idx`=0; goes to RST.
  - `start` in any other state is ignored.
- RST:
  - `core_reset`=1 for exactly RST_CYCLES cycles, then RUN.
  - `core_done` is ignored.
- RUN:
  - `core_reset`=0.
  - `cyc_ct` clears on entry and then increments once per cycle.
  - `core_done` sampled high goes to READ; `cyc_ct` includes that cycle.
  - If `cyc_ct` reaches TIMEOUT with no done: set `timeout[prog_idx]`=1, leave `pass[prog_idx]`=0, skip READ and CHECK, go to NEXT.
  - Done and timeout in the same cycle: done wins.
- READ:
  - One-cycle read latency: address presented in cycle n, data captured in cycle n+1.
  - prog 0: addr 4 goes to `result1[15:8]`, then addr 5 goes to `result1[7:0]`; back-to-back, 3 cycles.
  - prog 1: addr 7 goes to `result2`; 2 cycles.
  - prog 2: addr 127 goes to `result3`; 2 cycles.
  - `dm_ren` is high only on address cycles.
  - `core_reset` is reasserted on READ entry so the core stops.
- CHECK, one cycle: `pass[prog_idx]` = (result == latched exp).
- NEXT:
  - If `prog_idx` < 2: increment it and go to RST.
  - Else go to DONE: `all_done`=1, `busy`=0.
- `core_done` seen outside RUN is ignored.
- `cyc_ct` never wraps; it is bounded by TIMEOUT.

Test Plan:
1. Nominal run. Memory model: mem[4]=0x70, mem[5]=0xC8, mem[7]=5, mem[127]=3. Core model raises done 10 cycles after release. Set exp1=0x70C8 (255*255*200 mod 2^16), exp2=5, exp3=3, then pulse start. Required: `pass`=3'b111, `timeout`=0, `result1`=0x70C8, `cyc_ct`=10, `all_done`=1.
2. Mismatch. Same as scenario 1 but mem[127]=4. Required: `pass`=3'b011, `result3`=4, `all_done`=1.
3. Timeout. TIMEOUT=100, core never signals done on program 1. Required: `timeout`=3'b010, `pass[1]`=0, `cyc_ct`=100 at NEXT; program 2 still runs and `pass[2]`=1.
4. Launch timing. RST_CYCLES=2. Required: exactly 2 cycles of `core_reset`=1 before each release. `core_done` forced high during RST is ignored, with `cyc_ct` starting at 1 in the first RUN cycle. `start` pulsed during RUN has no effect.
5. Reset mid-RUN on program 1. Required: next cycle `core_reset`=1, `busy`=0, `prog_idx`=0, `pass`=0. A later `core_done` pulse is ignored.
6. Restart from DONE after scenario 2 with corrected expected values. Required: flags clear on `start`, then the full run gives `pass`=3'b111.
